mac_pe_vec: RTL and testbench
=============================

# mac_pe_vec

Vectorised, pipelined multiply-accumulate processing element. It is the parametrised successor to the scalar weight-stationary MAC. Each cycle it computes a LANES-wide signed dot product of activations and locally held weights, then adds the result either to an incoming partial sum (systolic mode) or to an internal accumulator (output-stationary mode). It tiles into the RPAccel systolic array: activations, weights and partial sums are forwarded to neighbouring PEs.

## Interface
- LANES, 4: number of parallel multipliers (≥1).
- BIT_WIDTH, 8: signed activation/weight width.
- ACC_WIDTH_CURR, 32: signed width of incoming partial sum.
- ACC_WIDTH_NEXT, 32: signed width of outgoing partial sum (≥ ACC_WIDTH_CURR).

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- wt_load  in  1  shift wt_path_in into shadow weight register.
- wt_path_in  in  LANES*BIT_WIDTH  weight chain input; lane i at bits [i*BIT_WIDTH +: BIT_WIDTH].
- wt_path_out  out  LANES*BIT_WIDTH  shadow weight register (chain output).
- wt_swap  in  1  copy shadow weights into active weights.
- in_valid  in  1  data_in/acc_in valid this cycle.
- data_in  in  LANES*BIT_WIDTH  signed activations.
- acc_in  in  ACC_WIDTH_CURR  signed incoming partial sum.
- acc_mode  in  1  0 = systolic (acc_in + dot), 1 = output-stationary (local accumulator + dot).
- acc_clear  in  1  with in_valid in mode 1: start a new accumulation (0 + dot).
- data_out  out  LANES*BIT_WIDTH  data_in forwarded one cycle later.
- data_valid_out  out  1  in_valid delayed one cycle.
- acc_out  out  ACC_WIDTH_NEXT  result.
- out_valid  out  1  acc_out valid this cycle.

## Operation
- Weights are double-buffered, so the next tile loads while the current one computes.
  - wt_load: shadow ← wt_path_in.
  - wt_swap: active ← shadow.
  - Both asserted in the same cycle: active takes the old shadow value; shadow takes the new wt_path_in.
- Stage 1, registered when in_valid:
  - prod[i] = data_in[i] × active_wt[i], each 2*BIT_WIDTH signed.
  - acc_in, acc_mode and acc_clear are captured alongside.
  - data_out/data_valid_out are registered from the same cycle; data_out holds when in_valid=0.
- Stage 2: dot = signed sum of prod, width 2*BIT_WIDTH+$clog2(LANES)+1.
  - Mode 0: acc_out = sext(acc_in_q) + sext(dot).
  - Mode 1: acc_reg = (acc_clear_q ? 0 : acc_reg) + dot, and acc_out = acc_reg's new value.
  - out_valid = stage-1 valid delayed one cycle.
- Arithmetic is two's complement at ACC_WIDTH_NEXT and wraps on overflow, unless MAC_SAT_EN is defined.
- Bubbles (in_valid=0) advance the pipeline but hold acc_out, acc_reg and data_out.
- Mode may change per beat. The mode is carried with the beat, so in-flight beats are unaffected.
- A wt_swap takes effect for beats whose in_valid arrives the cycle after the swap. Earlier beats use the old weights.

## Timing
- Latency: in_valid at cycle N → out_valid/acc_out at N+2. data_out at N+1.
- Throughput: one beat per cycle with no stall. There is no backpressure; downstream must accept every out_valid.
- wt_load → wt_path_out visible next cycle, giving a one-cycle-per-PE weight chain.
- Reset (rst_n=0 at an edge) clears all of the following to zero and drops in-flight beats:
  - shadow and active weights, pipeline registers and acc_reg;
  - wt_path_out, data_out, data_valid_out, acc_out and out_valid.
- Reset mid-accumulation discards acc_reg. The first mode-1 beat after reset needs no acc_clear, because acc_reg is already zero.

## Configuration
- MAC_SAT_EN defined: the stage-2 add saturates to [−2^(ACC_WIDTH_NEXT−1), 2^(ACC_WIDTH_NEXT−1)−1] in both modes. acc_reg stores the saturated value.
- MAC_SAT_EN undefined: the stage-2 add wraps modulo 2^ACC_WIDTH_NEXT. There is no extra logic.

## Test plan
- Reset: drive all inputs nonzero with rst_n=0 for 2 cycles → every output is 0. The first valid beat afterwards yields acc_out=acc_in, because the weights are 0.
- Systolic dot, LANES=4:
  - Load weights {1,2,3,4}, then swap.
  - Beat data {1,1,1,1}, acc_in=10 → acc_out=20 at N+2.
  - Beat data {−128,0,0,0} → acc_out=acc_in−128.
- Double buffer:
  - Load {1,1,1,1} and swap.
  - Stream data {1,1,1,1} every cycle while loading {2,2,2,2}; swap at cycle K.
  - Beats issued ≤K give 4; beats issued >K give 8.
  - Simultaneous wt_load+wt_swap: active takes the old shadow value.
- Output-stationary: weights {1,1,1,1}, mode 1, beats data {1,1,1,1} ×3 with acc_clear on the first, bubbles interleaved → acc_out 4, 8, 12. acc_clear on the 4th beat → 4.
- Overflow: ACC_WIDTH_NEXT=16, acc_in=32767, dot=1.
  - Without MAC_SAT_EN: acc_out=−32768.
  - With MAC_SAT_EN: acc_out=32767. The symmetric negative case gives −32768.
- Reset mid-stream: assert rst_n=0 while 2 beats are in flight → no out_valid for those beats. acc_reg is 0 on the next mode-1 beat.

Source files
------------

// File: rtl/mac_pe_vec.sv
// Vectorised two-stage signed MAC processing element with double-buffered weights.
// Define MAC_SAT_EN to saturate the stage-2 add; otherwise it wraps at ACC_WIDTH_NEXT.
module mac_pe_vec #(
    parameter int unsigned LANES          = 4,
    parameter int unsigned BIT_WIDTH      = 8,
    parameter int unsigned ACC_WIDTH_CURR = 32,
    parameter int unsigned ACC_WIDTH_NEXT = 32
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         wt_load,
    input  logic [LANES*BIT_WIDTH-1:0]   wt_path_in,
    output logic [LANES*BIT_WIDTH-1:0]   wt_path_out,
    input  logic                         wt_swap,
    input  logic                         in_valid,
    input  logic [LANES*BIT_WIDTH-1:0]   data_in,
    input  logic [ACC_WIDTH_CURR-1:0]    acc_in,
    input  logic                         acc_mode,
    input  logic                         acc_clear,
    output logic [LANES*BIT_WIDTH-1:0]   data_out,
    output logic                         data_valid_out,
    output logic [ACC_WIDTH_NEXT-1:0]    acc_out,
    output logic                         out_valid
);

    localparam int unsigned BW = BIT_WIDTH;
    localparam int unsigned VW = LANES * BIT_WIDTH;
    localparam int unsigned PW = 2 * BIT_WIDTH;
    localparam int unsigned DW = PW + $clog2(LANES) + 1;
    localparam int unsigned AC = ACC_WIDTH_CURR;
    localparam int unsigned AN = ACC_WIDTH_NEXT;
`ifdef MAC_SAT_EN
    localparam int unsigned SW = ((AN > DW) ? AN : DW) + 1;
`endif

    logic [VW-1:0]        wt_active;
    logic signed [PW-1:0] prod_c [LANES];
    logic signed [PW-1:0] prod_q [LANES];
    logic                 v1_q;
    logic signed [AC-1:0] acc_in_q;
    logic                 mode_q;
    logic                 clear_q;
    logic signed [DW-1:0] dot_c;
    logic signed [AN-1:0] base_c;
    logic signed [AN-1:0] res_c;
    logic signed [AN-1:0] acc_reg;
`ifdef MAC_SAT_EN
    logic signed [SW-1:0] sum_c;
`endif

    // Per-lane signed products against the active weights
    always_comb begin
        for (int i = 0; i < int'(LANES); i++) begin
            prod_c[i] = PW'($signed(data_in[i*BW +: BW])) * PW'($signed(wt_active[i*BW +: BW]));
        end
    end

    // Stage-2 dot product and accumulate
    always_comb begin
        dot_c = '0;
        for (int i = 0; i < int'(LANES); i++) begin
            dot_c = dot_c + DW'(prod_q[i]);
        end
        base_c = mode_q ? (clear_q ? '0 : acc_reg) : AN'(acc_in_q);
`ifdef MAC_SAT_EN
        sum_c = SW'(base_c) + SW'(dot_c);
        res_c = sum_c[AN-1:0];
        // Any disagreement among the bits above the result sign means overflow
        if (sum_c[SW-1:AN-1] != {(SW-AN+1){sum_c[SW-1]}}) begin
            res_c = sum_c[SW-1] ? {1'b1, {(AN-1){1'b0}}} : {1'b0, {(AN-1){1'b1}}};
        end
`else
        res_c = base_c + AN'(dot_c);
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wt_path_out    <= '0;
            wt_active      <= '0;
            prod_q         <= '{default: '0};
            v1_q           <= 1'b0;
            acc_in_q       <= '0;
            mode_q         <= 1'b0;
            clear_q        <= 1'b0;
            data_out       <= '0;
            data_valid_out <= 1'b0;
            acc_out        <= '0;
            out_valid      <= 1'b0;
            acc_reg        <= '0;
        end else begin
            // Swap reads the pre-load shadow, so load+swap together keeps the old tile
            if (wt_load) wt_path_out <= wt_path_in;
            if (wt_swap) wt_active   <= wt_path_out;
            v1_q           <= in_valid;
            data_valid_out <= in_valid;
            if (in_valid) begin
                prod_q   <= prod_c;
                acc_in_q <= acc_in;
                mode_q   <= acc_mode;
                clear_q  <= acc_clear;
                data_out <= data_in;
            end
            out_valid <= v1_q;
            if (v1_q) begin
                acc_out <= res_c;
                if (mode_q) acc_reg <= res_c;
            end
        end
    end

endmodule

// File: tb/tb_mac_pe_vec.sv
// Directed bench for mac_pe_vec (LANES=4, 8-bit data, 16-bit accumulators).
module tb_mac_pe_vec;

    localparam int unsigned LANES = 4;
    localparam int unsigned BW    = 8;
    localparam int unsigned AC    = 16;
    localparam int unsigned AN    = 16;
`ifdef MAC_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic              wt_load;
    logic [LANES*BW-1:0] wt_path_in;
    logic [LANES*BW-1:0] wt_path_out;
    logic              wt_swap;
    logic              in_valid;
    logic [LANES*BW-1:0] data_in;
    logic [AC-1:0]     acc_in;
    logic              acc_mode;
    logic              acc_clear;
    logic [LANES*BW-1:0] data_out;
    logic              data_valid_out;
    logic [AN-1:0]     acc_out;
    logic              out_valid;

    int checks = 0;
    int errors = 0;
    int expq [6];

    always #5 clk = ~clk;

    mac_pe_vec #(
        .LANES(LANES), .BIT_WIDTH(BW), .ACC_WIDTH_CURR(AC), .ACC_WIDTH_NEXT(AN)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .wt_load(wt_load), .wt_path_in(wt_path_in), .wt_path_out(wt_path_out),
        .wt_swap(wt_swap), .in_valid(in_valid), .data_in(data_in),
        .acc_in(acc_in), .acc_mode(acc_mode), .acc_clear(acc_clear),
        .data_out(data_out), .data_valid_out(data_valid_out),
        .acc_out(acc_out), .out_valid(out_valid)
    );

    function automatic logic [31:0] pk(input int a, input int b, input int c, input int d);
        return {8'(d), 8'(c), 8'(b), 8'(a)};
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [31:0] d, input int ai, input logic m, input logic c);
        in_valid  = 1'b1;
        data_in   = d;
        acc_in    = 16'(ai);
        acc_mode  = m;
        acc_clear = c;
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic load_swap(input logic [31:0] w);
        wt_load = 1'b1; wt_path_in = w; tick();
        wt_load = 1'b0; wt_swap = 1'b1; tick();
        wt_swap = 1'b0;
    endtask

    function automatic int sacc();
        return int'($signed(acc_out));
    endfunction

    initial begin
        // Reset with every input busy
        rst_n = 1'b0; wt_load = 1'b1; wt_path_in = pk(5, 6, 7, 8); wt_swap = 1'b1;
        beat(pk(1, 2, 3, 4), 100, 1'b1, 1'b1);
        tick(); tick();
        chk("rst_wt_path_out", int'(wt_path_out), 0);
        chk("rst_data_out", int'(data_out), 0);
        chk("rst_data_valid_out", int'(data_valid_out), 0);
        chk("rst_acc_out", sacc(), 0);
        chk("rst_out_valid", int'(out_valid), 0);

        // First beat after reset: zero weights pass acc_in through
        rst_n = 1'b1; wt_load = 1'b0; wt_swap = 1'b0;
        beat(pk(3, 3, 3, 3), 55, 1'b0, 1'b0);
        tick();
        chk("fwd_data_out", int'(data_out), int'(pk(3, 3, 3, 3)));
        chk("fwd_valid", int'(data_valid_out), 1);
        idle(); tick();
        chk("first_out_valid", int'(out_valid), 1);
        chk("first_acc_out", sacc(), 55);
        chk("bubble_dvo", int'(data_valid_out), 0);
        chk("bubble_data_hold", int'(data_out), int'(pk(3, 3, 3, 3)));
        tick();
        chk("bubble_out_valid", int'(out_valid), 0);
        chk("bubble_acc_hold", sacc(), 55);

        // Systolic dot products, back to back
        wt_load = 1'b1; wt_path_in = pk(1, 2, 3, 4); tick(); wt_load = 1'b0;
        chk("chain_out", int'(wt_path_out), int'(pk(1, 2, 3, 4)));
        wt_swap = 1'b1; tick(); wt_swap = 1'b0;
        beat(pk(1, 1, 1, 1), 10, 1'b0, 1'b0); tick();
        beat(pk(-128, 0, 0, 0), 50, 1'b0, 1'b0); tick();
        chk("sys_dot_valid", int'(out_valid), 1);
        chk("sys_dot_20", sacc(), 20);
        beat(pk(-1, 2, -3, 4), -1000, 1'b0, 1'b0); tick();
        chk("sys_neg128", sacc(), -78);
        idle(); tick();
        chk("sys_mixed_sign", sacc(), -990);
        tick();
        chk("sys_drain_valid", int'(out_valid), 0);

        // Double buffer: stream while loading, swap at cycle 2
        load_swap(pk(1, 1, 1, 1));
        for (int c = 0; c < 6; c++) begin
            beat(pk(1, 1, 1, 1), 0, 1'b0, 1'b0);
            wt_load = (c == 0); wt_path_in = pk(2, 2, 2, 2);
            wt_swap = (c == 2);
            expq[c] = (c <= 2) ? 4 : 8;
            tick();
            if (c >= 1) chk($sformatf("dbuf_beat%0d", c - 1), sacc(), expq[c-1]);
        end
        wt_load = 1'b0; wt_swap = 1'b0; idle(); tick();
        chk("dbuf_beat5", sacc(), expq[5]);

        // Simultaneous load+swap: active gets the old shadow
        wt_load = 1'b1; wt_path_in = pk(5, 5, 5, 5); tick();
        wt_path_in = pk(3, 3, 3, 3); wt_swap = 1'b1; tick();
        wt_load = 1'b0; wt_swap = 1'b0;
        chk("ldswap_shadow", int'(wt_path_out), int'(pk(3, 3, 3, 3)));
        beat(pk(1, 1, 1, 1), 0, 1'b0, 1'b0); tick(); idle(); tick();
        chk("ldswap_active", sacc(), 20);

        // Output-stationary accumulation with bubbles and a mode-0 beat in between
        load_swap(pk(1, 1, 1, 1));
        beat(pk(1, 1, 1, 1), 999, 1'b1, 1'b1); tick(); idle(); tick();
        chk("os_first", sacc(), 4);
        chk("os_first_valid", int'(out_valid), 1);
        tick();
        chk("os_bubble_valid", int'(out_valid), 0);
        chk("os_bubble_hold", sacc(), 4);
        beat(pk(1, 1, 1, 1), 999, 1'b1, 1'b0); tick(); idle(); tick();
        chk("os_second", sacc(), 8);
        beat(pk(1, 1, 1, 1), 999, 1'b1, 1'b0); tick(); idle(); tick();
        chk("os_third", sacc(), 12);
        beat(pk(1, 1, 1, 1), 7, 1'b0, 1'b0); tick();
        beat(pk(1, 1, 1, 1), 999, 1'b1, 1'b0); tick();
        chk("os_mode0_mix", sacc(), 11);
        beat(pk(1, 1, 1, 1), 999, 1'b1, 1'b1); tick();
        chk("os_keep_acc", sacc(), 16);
        idle(); tick();
        chk("os_clear", sacc(), 4);

        // Overflow at 16 bits: wrap or saturate
        beat(pk(1, 0, 0, 0), 32767, 1'b0, 1'b0); tick();
        beat(pk(-1, 0, 0, 0), -32768, 1'b0, 1'b0); tick();
        chk("ovf_pos", sacc(), SAT ? 32767 : -32768);
        idle(); tick();
        chk("ovf_neg", sacc(), SAT ? -32768 : 32767);
        load_swap(pk(127, 127, 127, 127));
        beat(pk(127, 127, 127, 127), 0, 1'b1, 1'b1); tick();
        beat(pk(-1, 0, 0, 0), 0, 1'b1, 1'b0); tick();
        chk("ovf_os_big", sacc(), SAT ? 32767 : -1020);
        idle(); tick();
        chk("ovf_os_stored", sacc(), SAT ? 32640 : -1147);

        // Reset with two beats in flight discards them and acc_reg
        load_swap(pk(1, 1, 1, 1));
        beat(pk(1, 1, 1, 1), 0, 1'b1, 1'b1); tick(); idle(); tick();
        chk("mid_pre", sacc(), 4);
        beat(pk(1, 1, 1, 1), 0, 1'b1, 1'b0); tick();
        beat(pk(1, 1, 1, 1), 0, 1'b1, 1'b0); rst_n = 1'b0; tick();
        chk("mid_rst_valid", int'(out_valid), 0);
        chk("mid_rst_acc", sacc(), 0);
        chk("mid_rst_dvo", int'(data_valid_out), 0);
        rst_n = 1'b1; idle(); tick();
        chk("mid_post_valid", int'(out_valid), 0);
        load_swap(pk(1, 1, 1, 1));
        beat(pk(1, 1, 1, 1), 0, 1'b1, 1'b0); tick(); idle(); tick();
        chk("mid_acc_fresh", sacc(), 4);
        chk("mid_acc_valid", int'(out_valid), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
